mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline: the consumer of the EX/MEM register outputs.
- Drives loads and stores onto a variable-latency data-memory req/ack port and stalls upstream while a request is outstanding.
- Resolves the branch decision (pcSrcM) and registers results into the MEM/WB register for writeback.

Parameters:
- WORD, 32, datapath and address width.
- REG_SIZE, 5, register-index width.
- TIMEOUT, 16, maximum cycles in WAIT before the access is aborted (must be ≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- writeDataM  in  WORD  store data.
- ALUResultM  in  WORD  memory address, or ALU result to forward.
- pcM  in  WORD  instruction PC, carried for debug only.
- writeRegM  in  REG_SIZE  destination register.
- regWriteM, memWriteM, mem2regM, zeroM, branchM  in  1 each  control bits from EX/MEM.
- dmemReq  out  1  request valid.
- dmemWe  out  1  1 = store, 0 = load.
- dmemAddr  out  WORD  word address.
- dmemWdata  out  WORD  store data.
- dmemAck  in  1  request complete.
- dmemRdata  in  WORD  load data, valid when dmemAck = 1.
- stallM  out  1  hold EX/MEM and all earlier stages.
- pcSrcM  out  1  branch taken.
- readDataW, ALUResultW  out  WORD  MEM/WB register data.
- writeRegW  out  REG_SIZE  MEM/WB destination register.
- regWriteW, mem2regW  out  1  MEM/WB control.
- memErr  out  1  sticky error flag.
- clearErr  in  1  synchronous clear of memErr.

Behaviour:
- Reset (async, active-high):
  - State = IDLE; timeout counter = 0.
  - All W outputs = 0; memErr = 0.
  - dmemReq = 0.
- Definitions:
  - memOp = memWriteM | mem2regM.
  - misaligned = ALUResultM[1:0] != 0.
- Combinational request outputs:
  - dmemAddr = ALUResultM, dmemWdata = writeDataM, dmemWe = memWriteM.
  - Upstream guarantees these inputs stay stable while stallM = 1.
- pcSrcM = branchM & zeroM & ~stallM. No redirect is issued while stalled.
- State IDLE:
  - No memOp: dmemReq = 0, stallM = 0. On the next edge, W regs load {ALUResultM, writeRegM, regWriteM, mem2regM}; readDataW = 0.
  - memOp & misaligned: no request, stallM = 0. Next edge writes a bubble (regWriteW = 0, mem2regW = 0) and sets memErr.
  - memOp & aligned: dmemReq = 1.
    - dmemAck = 1 the same cycle: stallM = 0; on the edge, readDataW = dmemRdata (loads) and W regs take the instruction.
    - Otherwise: stallM = 1, go to WAIT, counter = 1.
- State WAIT:
  - dmemReq = 1, stallM = 1 except in the ack cycle. W regs hold a bubble each cycle (regWriteW = 0).
  - On dmemAck: stallM = 0, capture as in IDLE, return to IDLE, counter = 0.
  - On counter == TIMEOUT with no ack: dmemReq = 0, stallM = 0, write a bubble, set memErr, return to IDLE.
  - Otherwise the counter increments.
- Simultaneous events:
  - dmemAck on the TIMEOUT cycle: ack wins, normal completion.
  - clearErr together with a new error: set wins.
  - dmemAck while dmemReq = 0: ignored.
- Store completion: regWriteW passes regWriteM (normally 0); readDataW = 0.
- Reset asserted mid-WAIT: immediate return to IDLE, dmemReq drops asynchronously. The memory side must discard the request.
- Single-cycle access latency is 1 cycle (IDLE → W regs on the next edge). Each wait cycle adds 1.

Test Plan:
- ALU op, no memory: ALUResultM = 0x0000_0010, writeRegM = 5, regWriteM = 1 → next cycle ALUResultW = 0x10, writeRegW = 5, regWriteW = 1, stallM never asserted.
- Load with dmemAck returned the same cycle: addr 0x100, dmemRdata = 0xDEAD_BEEF → readDataW = 0xDEADBEEF, mem2regW = 1, no stall.
- Load, ack after 3 cycles: stallM = 1 for 3 cycles, regWriteW = 0 in those cycles, dmemReq/dmemAddr held stable; then readDataW = dmemRdata and stallM falls.
- Store to misaligned addr 0x102 → dmemReq stays 0, bubble written, memErr = 1; clearErr = 1 → memErr = 0 next cycle.
- Timeout with TIMEOUT = 4: never ack → dmemReq high for exactly 4 cycles then drops, memErr = 1; separately, ack on the 4th cycle → normal completion, memErr = 0.
- Reset pulse mid-WAIT → dmemReq, stallM, and regWriteW = 0 immediately; state IDLE; branchM = 1 & zeroM = 1 afterwards → pcSrcM = 1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on a variable-latency req/ack port,
// stalls upstream while an access is outstanding, aborts on timeout,
// resolves the branch decision and fills the MEM/WB register.
module mem_stage #(
    parameter int WORD     = 32,
    parameter int REG_SIZE = 5,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD-1:0]     writeDataM,
    input  logic [WORD-1:0]     ALUResultM,
    input  logic [WORD-1:0]     pcM,
    input  logic [REG_SIZE-1:0] writeRegM,
    input  logic                regWriteM,
    input  logic                memWriteM,
    input  logic                mem2regM,
    input  logic                zeroM,
    input  logic                branchM,
    output logic                dmemReq,
    output logic                dmemWe,
    output logic [WORD-1:0]     dmemAddr,
    output logic [WORD-1:0]     dmemWdata,
    input  logic                dmemAck,
    input  logic [WORD-1:0]     dmemRdata,
    output logic                stallM,
    output logic                pcSrcM,
    output logic [WORD-1:0]     readDataW,
    output logic [WORD-1:0]     ALUResultW,
    output logic [REG_SIZE-1:0] writeRegW,
    output logic                regWriteW,
    output logic                mem2regW,
    output logic                memErr,
    input  logic                clearErr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WORD-1:0]     read_data_q, read_data_d;
    logic [WORD-1:0]     alu_result_q, alu_result_d;
    logic [REG_SIZE-1:0] write_reg_q, write_reg_d;
    logic                reg_write_q, reg_write_d;
    logic                mem2reg_q, mem2reg_d;
    logic                mem_err_q, mem_err_d;

    logic mem_op;
    logic misaligned;
    logic req;
    logic stall;
    logic capture;
    logic set_err;

    // The PC travels with the instruction for debug visibility only.
    logic unused_pc;
    assign unused_pc = ^pcM;

    assign mem_op     = memWriteM | mem2regM;
    assign misaligned = |ALUResultM[1:0];

    // Request payload is taken straight from EX/MEM; upstream holds it during a stall.
    assign dmemAddr  = ALUResultM;
    assign dmemWdata = writeDataM;
    assign dmemWe    = memWriteM;

    // Reset gates the handshake outputs so an outstanding request vanishes at once.
    assign dmemReq = req & ~reset;
    assign stallM  = stall & ~reset;
    assign pcSrcM  = branchM & zeroM & ~stallM;

    assign readDataW  = read_data_q;
    assign ALUResultW = alu_result_q;
    assign writeRegW  = write_reg_q;
    assign regWriteW  = reg_write_q;
    assign mem2regW   = mem2reg_q;
    assign memErr     = mem_err_q;

    // Access FSM: decides request, stall, capture-vs-bubble and error set.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        capture = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    capture = 1'b1;
                end else if (misaligned) begin
                    set_err = 1'b1;
                end else begin
                    req = 1'b1;
                    if (dmemAck) begin
                        capture = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                // An ack arriving on the final allowed cycle still completes normally.
                if (dmemAck) begin
                    req     = 1'b1;
                    capture = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    req   = 1'b1;
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB next value: the instruction when it completes, otherwise a bubble.
    always_comb begin
        read_data_d  = '0;
        alu_result_d = '0;
        write_reg_d  = '0;
        reg_write_d  = 1'b0;
        mem2reg_d    = 1'b0;
        if (capture) begin
            alu_result_d = ALUResultM;
            write_reg_d  = writeRegM;
            reg_write_d  = regWriteM;
            mem2reg_d    = mem2regM;
            if (mem2regM && !memWriteM) begin
                read_data_d = dmemRdata;
            end
        end
    end

    // Sticky error: a new error wins over a simultaneous clear.
    always_comb begin
        mem_err_d = mem_err_q;
        if (set_err) begin
            mem_err_d = 1'b1;
        end else if (clearErr) begin
            mem_err_d = 1'b0;
        end
    end

    // State, timeout counter, MEM/WB register and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem2reg_q    <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem2reg_q    <= mem2reg_d;
            mem_err_q    <= mem_err_d;
        end
    end

endmodule
